// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end.
// One outstanding imem request, stall hold buffer, branch redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        discard, discard_n;
  logic        hold_full, hold_full_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic [31:0] pc_n, inst_n;
  logic        valid_n;
  logic [31:0] pc_inc;

  assign pc_inc    = fetch_pc + 32'd4;
  assign imem_req  = (state == S_REQ);
  assign imem_addr = fetch_pc;

  // Next-state, fetch PC, hold buffer and output-register updates.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    discard_n   = discard;
    hold_full_n = hold_full;
    hold_pc_n   = hold_pc;
    hold_inst_n = hold_inst;
    pc_n        = if_pc;
    inst_n      = if_inst;
    valid_n     = if_valid;

    // No delivery this cycle: bubble unless stalled.
    if (!stall_i) begin
      inst_n  = '0;
      valid_n = 1'b0;
    end

    if (branch_flag_i) begin
      // Redirect wins over stall; in-flight data is dropped.
      fetch_pc_n  = {branch_target_i[31:2], 2'b00};
      inst_n      = '0;
      valid_n     = 1'b0;
      hold_full_n = 1'b0;
      unique case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            discard_n = 1'b1;
            state_n   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end
        S_HOLD: state_n = S_REQ;
        default: state_n = S_IDLE;
      endcase
    end else begin
      unique case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem_gnt) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else if (!stall_i) begin
              pc_n       = fetch_pc;
              inst_n     = imem_rdata;
              valid_n    = 1'b1;
              fetch_pc_n = pc_inc;
              state_n    = S_REQ;
            end else begin
              hold_full_n = 1'b1;
              hold_pc_n   = fetch_pc;
              hold_inst_n = imem_rdata;
              state_n     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            if (hold_full) begin
              pc_n    = hold_pc;
              inst_n  = hold_inst;
              valid_n = 1'b1;
            end
            hold_full_n = 1'b0;
            fetch_pc_n  = pc_inc;
            state_n     = S_REQ;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
      hold_full <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= '0;
      if_pc     <= '0;
      if_inst   <= '0;
      if_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      discard   <= discard_n;
      hold_full <= hold_full_n;
      hold_pc   <= hold_pc_n;
      hold_inst <= hold_inst_n;
      if_pc     <= pc_n;
      if_inst   <= inst_n;
      if_valid  <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch.
// PC-sequence model plus memory responder; literal checks pin key points.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'hFFFF_FFFC;
  localparam logic [31:0] K   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int errors = 0;
  int checks = 0;

  logic        gnt_en = 1'b1;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  logic [31:0] last_gnt = '0;

  logic        s_ok = 1'b0;
  logic        s_rst, s_br, s_stall, s_val;
  logic [31:0] s_tgt, s_pc, s_inst;
  logic [31:0] exp_pc = RPC;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid)
  );

  always #5 clk = ~clk;

  assign imem_gnt = gnt_en;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_deliv(input logic [31:0] pc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_valid === 1'b1 && if_pc === pc) && n < 20);
    chk("wait_deliv_pc", if_pc, pc);
    chk1("wait_deliv_valid", if_valid, 1'b1);
  endtask

  // Memory: answers addr^K, rvalid lat cycles after the grant cycle.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= paddr ^ K;
        pend        <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem_req && imem_gnt) begin
      last_gnt <= imem_addr;
      if (lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= imem_addr ^ K;
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  // Capture what the DUT samples at each edge.
  always @(posedge clk) begin
    s_ok    <= 1'b1;
    s_rst   <= rst;
    s_br    <= branch_flag_i;
    s_tgt   <= branch_target_i;
    s_stall <= stall_i;
    s_pc    <= if_pc;
    s_inst  <= if_inst;
    s_val   <= if_valid;
  end

  // Model: expected fetch PC sequence; check outputs every cycle.
  initial forever begin
    @(negedge clk);
    if (s_ok) begin
      if (s_rst) begin
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk1("rst_valid", if_valid, 1'b0);
        chk1("rst_req", imem_req, 1'b0);
        exp_pc = RPC;
      end else if (s_br) begin
        chk1("br_valid", if_valid, 1'b0);
        chk("br_inst", if_inst, 32'h0);
        chk("br_pc_hold", if_pc, s_pc);
        exp_pc = s_tgt & 32'hFFFF_FFFC;
      end else if (s_stall) begin
        chk("stall_pc", if_pc, s_pc);
        chk("stall_inst", if_inst, s_inst);
        chk1("stall_valid", if_valid, s_val);
      end else if (if_valid === 1'b1) begin
        chk("deliv_pc", if_pc, exp_pc);
        chk("deliv_inst", if_inst, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
      end else begin
        chk1("bubble_valid", if_valid, 1'b0);
        chk("bubble_inst", if_inst, 32'h0);
        chk("bubble_pc", if_pc, s_pc);
      end
      if (imem_req === 1'b1) chk("req_addr", imem_addr, exp_pc);
      if (imem_req && imem_gnt) chk1("one_outstanding", pend, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = '0;
    repeat (3) tick();
    chk1("reset_valid", if_valid, 1'b0);
    chk1("reset_req", imem_req, 1'b0);
    chk("reset_inst", if_inst, 32'h0);
    rst = 1'b0;
    tick();
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, RPC);

    // Back-to-back fetch, wrap from FFFF_FFFC to 0.
    wait_deliv(RPC);
    chk("t1_inst0", if_inst, 32'h5A5A_FFFC);
    tick();
    chk1("t1_bubble", if_valid, 1'b0);
    tick();
    chk1("t1_valid1", if_valid, 1'b1);
    chk("t1_wrap_pc", if_pc, 32'h0);
    chk("t1_wrap_inst", if_inst, 32'hA5A5_0000);
    tick();
    tick();
    chk("t1_pc4", if_pc, 32'h4);
    chk("t1_inst4", if_inst, 32'hA5A5_0004);
    chk("t2_req8", imem_addr, 32'h8);

    // Stall across the response for pc 8.
    stall_i = 1'b1;
    repeat (5) begin
      tick();
      chk("t2_frozen_pc", if_pc, 32'h4);
      chk1("t2_no_req", imem_req, 1'b0);
    end
    stall_i = 1'b0;
    tick();
    chk1("t2_rel_valid", if_valid, 1'b1);
    chk("t2_rel_pc", if_pc, 32'h8);
    chk("t2_rel_inst", if_inst, 32'hA5A5_0008);
    chk1("t2_req12", imem_req, 1'b1);
    chk("t2_addr12", imem_addr, 32'hC);

    // Branch in the same cycle as rvalid for pc 16.
    tick();
    tick();
    chk("t3_pc12", if_pc, 32'hC);
    chk("t3_addr16", imem_addr, 32'h10);
    tick();
    branch_flag_i = 1'b1;
    branch_target_i = 32'h0000_0103;
    tick();
    branch_flag_i = 1'b0;
    chk1("t3_drop_valid", if_valid, 1'b0);
    chk("t3_tgt_addr", imem_addr, 32'h100);
    tick();
    tick();
    chk("t3_tgt_pc", if_pc, 32'h100);
    chk("t3_tgt_inst", if_inst, 32'hA5A5_0100);

    // Branch while waiting, then again during the discard wait.
    lat = 3;
    tick();
    branch_flag_i = 1'b1;
    branch_target_i = 32'h180;
    tick();
    branch_target_i = 32'h200;
    chk1("t4_wait_req", imem_req, 1'b0);
    tick();
    branch_flag_i = 1'b0;
    chk1("t4_wait_req2", imem_req, 1'b0);
    chk1("t4_wait_valid", if_valid, 1'b0);
    tick();
    chk1("t4_stale_valid", if_valid, 1'b0);
    chk1("t4_req_tgt", imem_req, 1'b1);
    chk("t4_addr_tgt", imem_addr, 32'h200);
    wait_deliv(32'h200);
    chk("t4_inst", if_inst, 32'hA5A5_0200);

    // Grant withheld; branch moves the pending address.
    gnt_en = 1'b0;
    lat = 1;
    repeat (2) begin
      tick();
      chk1("t5_req_held", imem_req, 1'b1);
      chk("t5_addr_held", imem_addr, 32'h204);
    end
    branch_flag_i = 1'b1;
    branch_target_i = 32'h300;
    tick();
    branch_flag_i = 1'b0;
    chk("t5_addr_sw", imem_addr, 32'h300);
    tick();
    chk("t5_addr_sw2", imem_addr, 32'h300);
    gnt_en = 1'b1;
    wait_deliv(32'h300);
    chk("t5_last_gnt", last_gnt, 32'h300);

    // Reset during a wait; late response is ignored.
    lat = 3;
    tick();
    rst = 1'b1;
    gnt_en = 1'b0;
    tick();
    chk1("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_pc", if_pc, 32'h0);
    rst = 1'b0;
    tick();
    chk1("t6_req", imem_req, 1'b1);
    chk("t6_addr", imem_addr, RPC);
    tick();
    chk1("t6_late_valid", if_valid, 1'b0);
    chk("t6_addr2", imem_addr, RPC);
    lat = 1;
    gnt_en = 1'b1;
    wait_deliv(RPC);
    chk("t6_inst", if_inst, 32'h5A5A_FFFC);
    wait_deliv(32'h0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
